// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg: shared FSM state type and pattern length
package pattern_scan_ctrl_pkg;
  localparam int PAT_LEN = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, REPORT} state_t;
endpackage

// File: rtl/pattern_match_core.sv
// pattern_match_core: serial history register with registered pattern compare
module pattern_match_core
  import pattern_scan_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               res,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               match
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0] NEAR = FW'(PAT_LEN - 1);
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               match_q, match_d;
  logic [PAT_LEN-1:0] window;
  // Fill counts bits since the last clear; a non-overlapping match restarts it
  always_comb begin
    window  = {hist_q, bit_in};
    match_d = en && fill_q >= NEAR && window == pattern;
    hist_d  = en ? window[PAT_LEN-2:0] : hist_q;
    fill_d  = !en ? fill_q : (match_d && !overlap) ? '0 : (fill_q == FULL) ? fill_q : fill_q + 1'b1;
  end
  // History, fill level and the match pulse register
  always_ff @(posedge clk) begin
    if (res || clr) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end
  assign match = match_q;
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: word-serializing frame controller counting serial pattern hits
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               res,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_count,
  output logic               done,
  output logic               busy
);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer, start, en;
  assign in_ready  = state_q == IDLE || state_q == WAIT;
  assign busy      = state_q != IDLE;
  assign xfer      = in_valid && in_ready;
  assign start     = xfer && state_q == IDLE;
  // The live hit is folded in so the count is already final while done is high
  assign hit_count = cnt_q + CNT_W'(hit && !(&cnt_q));
  // Next-state: accept words, serialize MSB first, report at end of frame
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    bit_d   = bit_q;
    pat_d   = start ? cfg_pattern : pat_q;
    ovl_d   = start ? cfg_overlap : ovl_q;
    cnt_d   = start ? '0 : hit_count;
    en      = state_q == SHIFT;
    done    = state_q == REPORT;
    if (xfer) begin
      word_d  = in_data;
      last_d  = in_last;
      bit_d   = '0;
      state_d = SHIFT;
    end
    if (state_q == SHIFT) begin
      word_d  = word_q << 1;
      bit_d   = bit_q + 1'b1;
      state_d = (bit_q != LAST_BIT) ? SHIFT : last_q ? REPORT : WAIT;
    end
    if (state_q == REPORT) state_d = IDLE;
  end
  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      bit_q   <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
    end
  end
  pattern_match_core u_core (
    .clk     (clk),
    .res     (res),
    .clr     (start),
    .en      (en),
    .bit_in  (word_q[WORD_W-1]),
    .pattern (pat_q),
    .overlap (ovl_q),
    .match   (hit)
  );
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: scoreboard bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;
  logic       clk = 0, res = 1;
  logic [3:0] cfg_pattern = 0;
  logic       cfg_overlap = 0, in_valid = 0, in_last = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, hit, done, busy;
  logic [7:0] hit_count;
  logic [7:0] done_hc;
  int vecs = 0, errs = 0, done_cnt = 0, hit_cnt = 0, xfer_cnt = 0;
  int exp_hc_q[$], exp_hit_q[$];
  pattern_scan_ctrl dut (
    .clk(clk), .res(res), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .hit(hit), .hit_count(hit_count), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_hc = hit_count;
    end
    if (hit === 1'b1) hit_cnt++;
    if (in_valid && in_ready === 1'b1) xfer_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int model(input logic [3:0] pat, input logic ovl, input logic [7:0] ws[$]);
    int n = 0, c = 0;
    logic [3:0] h = 0;
    foreach (ws[i])
      for (int b = 7; b >= 0; b--) begin
        h = {h[2:0], ws[i][b]};
        n++;
        if (n >= 4 && h == pat) begin
          c++;
          if (!ovl) n = 0;
        end
      end
    return c;
  endfunction
  task automatic push_expect(input logic [3:0] pat, input logic ovl, input logic [7:0] ws[$]);
    int raw;
    raw = model(pat, ovl, ws);
    exp_hit_q.push_back(raw);
    exp_hc_q.push_back(raw > 255 ? 255 : raw);
  endtask
  task automatic send_word(input logic [7:0] d, input logic l, input bit hold);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (in_ready !== 1'b1 && n < 64) begin tick(); n++; end
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL send_word: in_ready=%b required 1 within 64 cycles", in_ready);
    end
    tick();
    if (!hold) in_valid = 0;
  endtask
  task automatic finish_frame(input string name, input int d0, input int h0, input int x0, input int nw);
    int n = 0, eh, ep;
    while (done_cnt == d0 && n < 100) begin tick(); n++; end
    repeat (2) tick();
    eh = exp_hc_q.pop_front();
    ep = exp_hit_q.pop_front();
    vecs++;
    if (done_cnt - d0 !== 1) begin errs++; $display("FAIL %s done pulses: got %0d required 1", name, done_cnt - d0); end
    vecs++;
    if (done_hc !== 8'(eh)) begin errs++; $display("FAIL %s hit_count at done: got %0d required %0d", name, done_hc, eh); end
    vecs++;
    if (hit_cnt - h0 !== ep) begin errs++; $display("FAIL %s hit pulses: got %0d required %0d", name, hit_cnt - h0, ep); end
    vecs++;
    if (xfer_cnt - x0 !== nw) begin errs++; $display("FAIL %s words consumed: got %0d required %0d", name, xfer_cnt - x0, nw); end
  endtask
  task automatic run_frame(input string name, input logic [3:0] pat, input logic ovl, input logic [7:0] ws[$], input bit hold);
    int d0, h0, x0;
    push_expect(pat, ovl, ws);
    cfg_pattern = pat; cfg_overlap = ovl;
    d0 = done_cnt; h0 = hit_cnt; x0 = xfer_cnt;
    foreach (ws[i]) begin
      send_word(ws[i], i == ws.size() - 1, hold && i != ws.size() - 1);
      if (i == 0) begin cfg_pattern = ~pat; cfg_overlap = ~ovl; end
    end
    finish_frame(name, d0, h0, x0, ws.size());
  endtask
  task automatic test_reset();
    res = 1;
    repeat (2) tick();
    vecs++;
    if ({in_ready, hit, hit_count, done, busy} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset outputs: rdy/hit/cnt/done/busy=%b/%b/%0d/%b/%b required 1/0/0/0/0", in_ready, hit, hit_count, done, busy);
    end
    res = 0;
    tick();
  endtask
  task automatic test_basic();
    run_frame("single_b6", 4'b1011, 1'b0, '{8'hB6}, 0);
    run_frame("ovl_5b", 4'b1011, 1'b1, '{8'h5B}, 0);
    run_frame("novl_5b", 4'b1011, 1'b0, '{8'h5B}, 0);
  endtask
  task automatic test_cross_word();
    int d0, h0, x0, low;
    push_expect(4'b1011, 1'b0, '{8'h01, 8'h60});
    cfg_pattern = 4'b1011; cfg_overlap = 0;
    d0 = done_cnt; h0 = hit_cnt; x0 = xfer_cnt;
    send_word(8'h01, 0, 0);
    low = 0;
    repeat (8) begin if (in_ready === 1'b0) low++; tick(); end
    vecs++;
    if (low !== 8) begin errs++; $display("FAIL cross gap1: in_ready low %0d cycles required 8", low); end
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL cross wait ready: got %b required 1", in_ready); end
    send_word(8'h60, 1, 0);
    low = 0;
    repeat (8) begin if (in_ready === 1'b0) low++; tick(); end
    vecs++;
    if (low !== 8) begin errs++; $display("FAIL cross gap2: in_ready low %0d cycles required 8", low); end
    finish_frame("cross_word", d0, h0, x0, 2);
  endtask
  task automatic test_saturate();
    logic [7:0] ws[$];
    repeat (40) ws.push_back(8'h00);
    run_frame("saturate", 4'b0000, 1'b1, ws, 0);
  endtask
  task automatic test_reset_mid();
    int d0;
    cfg_pattern = 4'b1011; cfg_overlap = 0;
    send_word(8'hB6, 1, 0);
    repeat (3) tick();
    res = 1;
    tick();
    vecs++;
    if ({in_ready, busy, hit_count, done} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid: rdy/busy/cnt/done=%b/%b/%0d/%b required 1/0/0/0", in_ready, busy, hit_count, done);
    end
    res = 0;
    d0 = done_cnt;
    repeat (12) tick();
    vecs++;
    if (done_cnt !== d0) begin errs++; $display("FAIL reset_mid done after abort: got %0d pulses required 0", done_cnt - d0); end
    run_frame("after_reset", 4'b1011, 1'b0, '{8'hB6}, 0);
  endtask
  task automatic test_back_to_back();
    run_frame("hold_valid", 4'b1011, 1'b0, '{8'h0B, 8'hB0, 8'h2D}, 1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ws[$];
      int nw = $urandom_range(1, 3);
      repeat (nw) ws.push_back(8'($urandom));
      run_frame("random", 4'($urandom), 1'($urandom), ws, k[0]);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_cross_word();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
